// File: rtl/otter_fetch_stage_if.sv
// rtl/otter_fetch_stage_if.sv - instruction-memory request/response bus of the fetch stage
interface otter_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/otter_fetch_stage.sv
// rtl/otter_fetch_stage.sv - OTTER instruction fetch: PC, imem requests, IF/ID register
module otter_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       reg_en,
    input  logic                       pc_write,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    otter_fetch_stage_if.master        imem,
    output logic [31:0]                decodeIR_out,
    output logic [31:0]                decode_pc,
    output logic                       decode_valid
);
    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD, ST_DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_inc, redirect_tgt;
    logic [31:0] buf_q, buf_nxt, fetch_word;
    logic [31:0] ir_nxt, dpc_nxt;
    logic        dv_nxt;
    logic        avail, commit, req;
    logic [31:0] addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ISSUE;
            pc           <= RESET_PC;
            buf_q        <= 32'h0;
            decodeIR_out <= NOP_INSN;
            decode_pc    <= 32'h0;
            decode_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            buf_q        <= buf_nxt;
            decodeIR_out <= ir_nxt;
            decode_pc    <= dpc_nxt;
            decode_valid <= dv_nxt;
        end
    end

    always_comb begin
        pc_inc       = pc + 32'd4;
        redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
        avail        = ((state == ST_WAIT) && imem.imem_valid) || (state == ST_HOLD);
        fetch_word   = (state == ST_HOLD) ? buf_q : imem.imem_rdata;
        commit       = reg_en && pc_write && avail && !redirect_valid;

        state_nxt = state;
        pc_nxt    = pc;
        buf_nxt   = buf_q;
        ir_nxt    = decodeIR_out;
        dpc_nxt   = decode_pc;
        dv_nxt    = decode_valid;
        req       = 1'b0;
        addr      = pc;

        // Redirect overrides stall: the wrong-path word must never reach decode.
        if (redirect_valid) begin
            pc_nxt  = redirect_tgt;
            buf_nxt = 32'h0;
            ir_nxt  = NOP_INSN;
            dpc_nxt = 32'h0;
            dv_nxt  = 1'b0;
        end else if (commit) begin
            pc_nxt  = pc_inc;
            ir_nxt  = fetch_word;
            dpc_nxt = pc;
            dv_nxt  = 1'b1;
        end else if (reg_en) begin
            ir_nxt  = NOP_INSN;
            dpc_nxt = 32'h0;
            dv_nxt  = 1'b0;
        end

        unique case (state)
            ST_ISSUE: begin
                if (!redirect_valid) begin
                    req       = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_nxt = imem.imem_valid ? ST_ISSUE : ST_DRAIN;
                end else if (imem.imem_valid) begin
                    if (commit) begin
                        // back-to-back: request the next word in the cycle this one lands
                        req  = 1'b1;
                        addr = pc_inc;
                    end else begin
                        buf_nxt   = imem.imem_rdata;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid || commit) state_nxt = ST_ISSUE;
            end
            ST_DRAIN: begin
                // the stale response retires the outstanding request even if redirected again
                if (imem.imem_valid) state_nxt = ST_ISSUE;
            end
            default: state_nxt = ST_ISSUE;
        endcase
    end

    assign imem.imem_req  = req & rst_n;
    assign imem.imem_addr = addr;
endmodule

// File: tb/tb_otter_fetch_stage.sv
// tb/tb_otter_fetch_stage.sv - self-checking bench for otter_fetch_stage
module tb_otter_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_en, pc_write, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] decodeIR_out, decode_pc;
    logic        decode_valid;

    int n_tests = 0;
    int n_fail  = 0;

    otter_fetch_stage_if imem();

    otter_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_en         (reg_en),
        .pc_write       (pc_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .decodeIR_out   (decodeIR_out),
        .decode_pc      (decode_pc),
        .decode_valid   (decode_valid)
    );

    always #5 clk = ~clk;

    // reference model: pc, one outstanding request (possibly stale), one buffered word, IF/ID
    logic [31:0] m_pc, m_buf, m_ir, m_dpc;
    logic        m_out, m_stale, m_bv, m_dv;
    // memory: single pending response, returns its address as data
    logic        p_vld;
    int          p_cnt;
    logic [31:0] p_addr;
    int          lat_min, lat_max;
    logic        spur_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_buf = 32'h0; m_ir = NOP; m_dpc = 32'h0;
        m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0; m_dv = 1'b0;
        p_vld = 1'b0; p_cnt = 0; p_addr = 32'h0;
    endtask

    task automatic cycle(input logic re, input logic pw, input logic rv, input logic [31:0] rpc);
        logic        v, from_mem, have, cm, er, idle;
        logic [31:0] rd, w, ea;
        @(negedge clk);
        reg_en = re; pc_write = pw; redirect_valid = rv; redirect_pc = rpc;
        v  = 1'b0;
        rd = $urandom;
        if (p_vld && p_cnt == 0) begin
            v  = 1'b1;
            rd = p_addr;
        end else if (spur_en && !p_vld && $urandom_range(0, 7) == 0) begin
            v = 1'b1;
        end
        imem.imem_valid = v;
        imem.imem_rdata = rd;
        #1;
        idle     = !m_out && !m_bv;
        from_mem = m_out && !m_stale && v;
        have     = from_mem || m_bv;
        w        = m_bv ? m_buf : rd;
        cm       = re && pw && have && !rv;
        er       = !rv && (idle || (from_mem && cm));
        ea       = idle ? m_pc : m_pc + 32'd4;

        chk("decodeIR_out", decodeIR_out, m_ir);
        chk("decode_pc", decode_pc, m_dpc);
        chk("decode_valid", {31'b0, decode_valid}, {31'b0, m_dv});
        chk("imem_req", {31'b0, imem.imem_req}, {31'b0, er});
        if (er) chk("imem_addr", imem.imem_addr, ea);

        if (p_vld) begin
            if (p_cnt == 0) p_vld = 1'b0;
            else p_cnt--;
        end
        if (imem.imem_req) begin
            p_vld  = 1'b1;
            p_cnt  = $urandom_range(lat_min, lat_max) - 1;
            p_addr = imem.imem_addr;
        end

        if (m_out && v) begin m_out = 1'b0; m_stale = 1'b0; end
        if (rv) begin
            if (m_out) m_stale = 1'b1;
            m_bv = 1'b0; m_pc = rpc & 32'hFFFF_FFFC;
            m_ir = NOP; m_dpc = 32'h0; m_dv = 1'b0;
        end else if (cm) begin
            m_ir = w; m_dpc = m_pc; m_dv = 1'b1;
            m_pc = m_pc + 32'd4; m_bv = 1'b0;
        end else begin
            if (from_mem) begin m_buf = rd; m_bv = 1'b1; end
            if (re) begin m_ir = NOP; m_dpc = 32'h0; m_dv = 1'b0; end
        end
        if (er) begin m_out = 1'b1; m_stale = 1'b0; end
    endtask

    initial begin
        reg_en = 1'b1; pc_write = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem.imem_valid = 1'b0; imem.imem_rdata = 32'h0;
        lat_min = 1; lat_max = 1; spur_en = 1'b0;
        model_reset();

        @(negedge clk); #1;
        chk("reset imem_req", {31'b0, imem.imem_req}, 32'd0);
        chk("reset decodeIR_out", decodeIR_out, NOP);
        chk("reset decode_valid", {31'b0, decode_valid}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // stream from reset, 1-cycle memory
        cycle(1, 1, 0, 0);
        chk("c0 imem_addr", imem.imem_addr, 32'h0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        chk("c2 decodeIR_out", decodeIR_out, 32'h0);
        chk("c2 decode_valid", {31'b0, decode_valid}, 32'd1);
        // stall three cycles while word 8 returns
        cycle(0, 0, 0, 0);
        chk("c3 decodeIR_out", decodeIR_out, 32'h4);
        chk("c3 decode_pc", decode_pc, 32'h4);
        cycle(0, 0, 0, 0);
        chk("stall frozen ir", decodeIR_out, 32'h4);
        chk("stall no req", {31'b0, imem.imem_req}, 32'd0);
        cycle(0, 0, 0, 0);
        chk("stall no req 2", {31'b0, imem.imem_req}, 32'd0);
        cycle(1, 1, 0, 0);
        chk("release no refetch", {31'b0, imem.imem_req}, 32'd0);
        lat_min = 3; lat_max = 3;
        cycle(1, 1, 0, 0);
        chk("buffered word", decodeIR_out, 32'h8);
        chk("buffered pc", decode_pc, 32'h8);
        chk("next addr 12", imem.imem_addr, 32'hC);
        // redirect with request outstanding
        cycle(1, 1, 1, 32'h100);
        cycle(1, 1, 0, 0);
        chk("redir bubble ir", decodeIR_out, NOP);
        chk("redir bubble valid", {31'b0, decode_valid}, 32'd0);
        lat_min = 1; lat_max = 1;
        cycle(1, 1, 0, 0);
        chk("stale dropped no req", {31'b0, imem.imem_req}, 32'd0);
        cycle(1, 1, 0, 0);
        chk("target req", {31'b0, imem.imem_req}, 32'd1);
        chk("target addr", imem.imem_addr, 32'h100);
        // redirect beats stall and an arriving word
        cycle(0, 0, 1, 32'h200);
        cycle(1, 1, 0, 0);
        chk("redir+stall ir", decodeIR_out, NOP);
        chk("redir+stall addr", imem.imem_addr, 32'h200);
        // unaligned target and wrap
        cycle(1, 1, 1, 32'hFFFF_FFFE);
        cycle(1, 1, 0, 0);
        chk("aligned target", imem.imem_addr, 32'hFFFF_FFFC);
        cycle(1, 1, 0, 0);
        chk("wrap addr", imem.imem_addr, 32'h0);
        cycle(0, 0, 0, 0);
        chk("top word ir", decodeIR_out, 32'hFFFF_FFFC);
        chk("top word pc", decode_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        // async reset while holding a buffered word
        #2 rst_n = 1'b0;
        #1;
        chk("async reset ir", decodeIR_out, NOP);
        chk("async reset valid", {31'b0, decode_valid}, 32'd0);
        chk("async reset pc", decode_pc, 32'h0);
        chk("async reset req", {31'b0, imem.imem_req}, 32'd0);
        model_reset();
        @(posedge clk); #2 rst_n = 1'b1;
        cycle(1, 1, 0, 0);
        chk("post reset addr", imem.imem_addr, 32'h0);

        // randomized stalls, redirects and memory latency
        lat_min = 1; lat_max = 4; spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 11) == 0, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
